mmc_gate_driver: RTL and testbench

- Consumes the 12-bit insertion mask M[12:1] from the capacitor-voltage sorter and drives the complementary half-bridge gate pair of each submodule.
- Inserts a dead time on every changed submodule and enforces a minimum dwell between mask updates.
- Sits between the sorter output and the gate-driver pins; it is the downstream end of the sorter's M interface.

---
 rtl/mmc_gate_driver_if.sv | 11 +
 rtl/mmc_gate_driver.sv | 98 +++++++++
 tb/tb_mmc_gate_driver.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mmc_gate_driver_if.sv
// Sorter-to-gate-driver mask handshake; a mask transfers on a clock edge with m_valid && m_ready.
interface mmc_gate_driver_if #(
    parameter int N_SM = 12
);
    logic            m_valid;
    logic [N_SM:1]   m_in;
    logic            m_ready;

    modport master (output m_valid, output m_in, input  m_ready);
    modport slave  (input  m_valid, input  m_in, output m_ready);
endinterface

// File: rtl/mmc_gate_driver.sv
// Half-bridge gate pair driver: changed submodules see DEADTIME cycles with both gates low, then MIN_DWELL hold.
// Latency: new gates DEADTIME edges after acceptance; m_ready (registered) returns DEADTIME+MIN_DWELL edges later.
module mmc_gate_driver #(
    parameter int N_SM      = 12,
    parameter int DEADTIME  = 10,
    parameter int MIN_DWELL = 50
) (
    input  logic                clk,
    input  logic                rst,
    mmc_gate_driver_if.slave    m,
    output logic [N_SM:1]       gate_hi,
    output logic [N_SM:1]       gate_lo,
    output logic [N_SM:1]       mask_applied,
    output logic [3:0]          n_inserted,
    output logic                busy
);

    localparam int CMAX = (DEADTIME > MIN_DWELL) ? DEADTIME : MIN_DWELL;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [1:0] ST_DEAD  = 2'd0;
    localparam logic [1:0] ST_DWELL = 2'd1;
    localparam logic [1:0] ST_IDLE  = 2'd2;

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic [N_SM:1]  target;
    logic [N_SM:1]  changed;
    logic [N_SM:1]  diff;

    assign diff = m.m_in ^ mask_applied;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Startup runs a full DEAD/DWELL pass toward an all-bypassed target.
            state        <= ST_DEAD;
            cnt          <= '0;
            target       <= '0;
            changed      <= '1;
            gate_hi      <= '0;
            gate_lo      <= '0;
            mask_applied <= '0;
            n_inserted   <= '0;
            m.m_ready    <= 1'b0;
            busy         <= 1'b1;
        end else begin
            case (state)
                ST_DEAD: begin
                    if (cnt == CW'(DEADTIME - 1)) begin
                        // Unchanged bits were never released, so only changed bits take the target.
                        gate_hi      <= (gate_hi & ~changed) | (target & changed);
                        gate_lo      <= (gate_lo & ~changed) | (~target & changed);
                        mask_applied <= target;
                        n_inserted   <= 4'($countones(target));
                        state        <= ST_DWELL;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DWELL: begin
                    if (cnt == CW'(MIN_DWELL - 1)) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        m.m_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    // An identical mask is consumed without restarting the dwell.
                    if (m.m_valid && m.m_ready && (diff != '0)) begin
                        target    <= m.m_in;
                        changed   <= diff;
                        gate_hi   <= gate_hi & ~diff;
                        gate_lo   <= gate_lo & ~diff;
                        state     <= ST_DEAD;
                        cnt       <= '0;
                        m.m_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_DEAD;
                    cnt       <= '0;
                    target    <= '0;
                    changed   <= '1;
                    gate_hi   <= '0;
                    gate_lo   <= '0;
                    m.m_ready <= 1'b0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmc_gate_driver.sv
// Directed bench for mmc_gate_driver with DEADTIME=4, MIN_DWELL=8.
module tb_mmc_gate_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:1] gate_hi, gate_lo, mask_applied;
    logic [3:0]  n_inserted;
    logic        busy;
    int          total = 0;
    int          bad   = 0;

    mmc_gate_driver_if #(.N_SM(12)) mif ();

    mmc_gate_driver #(.N_SM(12), .DEADTIME(4), .MIN_DWELL(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .m            (mif.slave),
        .gate_hi      (gate_hi),
        .gate_lo      (gate_lo),
        .mask_applied (mask_applied),
        .n_inserted   (n_inserted),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Shoot-through guard, sampled mid-cycle on every cycle including reset.
    always @(negedge clk) chk("no_overlap", 32'(gate_hi & gate_lo), 32'h0);

    // Reset-release startup: bypass after edge 4, ready after edge 12.
    task automatic startup_seq(input string tag);
        for (int e = 1; e <= 3; e++) begin
            step(1);
            chk({tag, "_hi_pre"}, 32'(gate_hi), 32'h0);
            chk({tag, "_lo_pre"}, 32'(gate_lo), 32'h0);
        end
        step(1);
        chk({tag, "_lo_e4"}, 32'(gate_lo), 32'hFFF);
        chk({tag, "_hi_e4"}, 32'(gate_hi), 32'h0);
        chk({tag, "_n_e4"}, 32'(n_inserted), 32'h0);
        for (int e = 5; e <= 11; e++) begin
            step(1);
            chk({tag, "_rdy_dwell"}, 32'(mif.m_ready), 32'h0);
        end
        step(1);
        chk({tag, "_rdy_e12"}, 32'(mif.m_ready), 32'h1);
        chk({tag, "_busy_e12"}, 32'(busy), 32'h0);
        chk({tag, "_mask_e12"}, 32'(mask_applied), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        mif.m_valid = 1'b0;
        mif.m_in = '0;
        step(2);
        chk("rst_hi", 32'(gate_hi), 32'h0);
        chk("rst_lo", 32'(gate_lo), 32'h0);
        chk("rst_mask", 32'(mask_applied), 32'h0);
        chk("rst_n", 32'(n_inserted), 32'h0);
        chk("rst_rdy", 32'(mif.m_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        startup_seq("start");

        // 000 -> 001
        mif.m_valid = 1'b1; mif.m_in = 12'h001;
        step(1);
        mif.m_valid = 1'b0; mif.m_in = 12'hABC;
        chk("a_lo", 32'(gate_lo), 32'hFFE);
        chk("a_hi", 32'(gate_hi), 32'h0);
        chk("a_rdy", 32'(mif.m_ready), 32'h0);
        chk("a_busy", 32'(busy), 32'h1);
        step(3);
        chk("a_hi_dead", 32'(gate_hi), 32'h0);
        step(1);
        chk("a_hi_new", 32'(gate_hi), 32'h001);
        chk("a_lo_new", 32'(gate_lo), 32'hFFE);
        chk("a_n", 32'(n_inserted), 32'd1);
        chk("a_mask", 32'(mask_applied), 32'h001);
        step(7);
        chk("a_rdy_e11", 32'(mif.m_ready), 32'h0);
        step(1);
        chk("a_rdy_e12", 32'(mif.m_ready), 32'h1);

        // 001 -> 003: only bit 2 released, bit 1 stays inserted
        mif.m_valid = 1'b1; mif.m_in = 12'h003;
        step(1);
        mif.m_valid = 1'b0;
        for (int e = 0; e < 4; e++) begin
            chk("b_hi_dead", 32'(gate_hi), 32'h001);
            chk("b_lo_dead", 32'(gate_lo), 32'hFFC);
            if (e < 3) step(1);
        end
        step(1);
        chk("b_hi_new", 32'(gate_hi), 32'h003);
        chk("b_lo_new", 32'(gate_lo), 32'hFFC);
        chk("b_n", 32'(n_inserted), 32'd2);
        step(8);
        chk("b_rdy", 32'(mif.m_ready), 32'h1);

        // Same mask again: nothing moves
        mif.m_valid = 1'b1; mif.m_in = 12'h003;
        step(1);
        mif.m_valid = 1'b0;
        chk("c_hi", 32'(gate_hi), 32'h003);
        chk("c_lo", 32'(gate_lo), 32'hFFC);
        chk("c_rdy", 32'(mif.m_ready), 32'h1);
        chk("c_busy", 32'(busy), 32'h0);
        step(1);
        chk("c_rdy2", 32'(mif.m_ready), 32'h1);
        chk("c_busy2", 32'(busy), 32'h0);

        // 003 -> 000, then FFF held valid through the dwell
        mif.m_valid = 1'b1; mif.m_in = 12'h000;
        step(1);
        mif.m_in = 12'hFFF;
        step(4);
        chk("d_lo_bypass", 32'(gate_lo), 32'hFFF);
        chk("d_hi_bypass", 32'(gate_hi), 32'h0);
        for (int e = 5; e <= 11; e++) begin
            step(1);
            chk("d_hi_ignored", 32'(gate_hi), 32'h0);
            chk("d_lo_ignored", 32'(gate_lo), 32'hFFF);
            chk("d_rdy_dwell", 32'(mif.m_ready), 32'h0);
        end
        step(1);
        chk("d_rdy_e12", 32'(mif.m_ready), 32'h1);
        chk("d_lo_e12", 32'(gate_lo), 32'hFFF);
        step(1);
        mif.m_valid = 1'b0;
        chk("d_lo_accept", 32'(gate_lo), 32'h0);
        chk("d_hi_accept", 32'(gate_hi), 32'h0);
        chk("d_rdy_accept", 32'(mif.m_ready), 32'h0);
        step(4);
        chk("d_hi_new", 32'(gate_hi), 32'hFFF);
        chk("d_n", 32'(n_inserted), 32'd12);
        step(8);
        chk("d_rdy_end", 32'(mif.m_ready), 32'h1);
        chk("d_mask", 32'(mask_applied), 32'hFFF);

        // Back to 000, then reset in the middle of the 000 -> FFF dead time
        mif.m_valid = 1'b1; mif.m_in = 12'h000;
        step(1);
        mif.m_valid = 1'b0;
        step(12);
        chk("e_rdy", 32'(mif.m_ready), 32'h1);
        chk("e_lo", 32'(gate_lo), 32'hFFF);
        mif.m_valid = 1'b1; mif.m_in = 12'hFFF;
        step(1);
        mif.m_valid = 1'b0;
        chk("e_lo_dead", 32'(gate_lo), 32'h0);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("e_rst_hi", 32'(gate_hi), 32'h0);
        chk("e_rst_lo", 32'(gate_lo), 32'h0);
        chk("e_rst_mask", 32'(mask_applied), 32'h0);
        chk("e_rst_rdy", 32'(mif.m_ready), 32'h0);
        chk("e_rst_busy", 32'(busy), 32'h1);
        startup_seq("restart");
        chk("e_final_lo", 32'(gate_lo), 32'hFFF);
        chk("e_final_hi", 32'(gate_hi), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
